ag_tcu_fadd_arbiter: RTL

Round-robin arbiter and in-flight tracker that shares one fixed-latency pipelined BF16/FP32 adder among `NUM_REQS` requesters in the AG tensor-core unit. It grants at most one operand pair per cycle into the adder and tags each issued operation with its requester index. It returns results in issue order with that tag. When the response consumer back-pressures, it stalls the whole adder pipeline through the adder's `enable` input.

---
 rtl/ag_tcu_fadd_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/ag_tcu_fadd_arbiter.sv
// rtl/ag_tcu_fadd_arbiter.sv - round-robin arbiter and in-flight tracker sharing one pipelined FP adder
// Results return in issue order, tagged with the issuing requester index.
module ag_tcu_fadd_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int FLEN     = 32,
    parameter int LATENCY  = 2,
    localparam int TAG_W   = $clog2(NUM_REQS),
    localparam int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        req_valid,
    output logic [NUM_REQS-1:0]        req_ready,
    input  logic [NUM_REQS*FLEN-1:0]   req_a,
    input  logic [NUM_REQS*FLEN-1:0]   req_b,
    input  logic [NUM_REQS*3-1:0]      req_frm,
    output logic                       fadd_enable,
    output logic [FLEN-1:0]            fadd_a,
    output logic [FLEN-1:0]            fadd_b,
    output logic [2:0]                 fadd_frm,
    input  logic [FLEN-1:0]            fadd_y,
    input  logic [4:0]                 fadd_fflags,
    output logic                       rsp_valid,
    output logic [TAG_W-1:0]           rsp_idx,
    output logic [FLEN-1:0]            rsp_y,
    output logic [4:0]                 rsp_fflags,
    input  logic                       rsp_ready,
    output logic                       busy,
    output logic [CNT_W-1:0]           pend_cnt
);

    logic [LATENCY-1:0]             r_vld;
    logic [LATENCY-1:0][TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]               r_ptr;
    logic [CNT_W-1:0]               r_pend_cnt;

    logic                           w_rsp_valid;
    logic                           w_enable;
    logic                           w_retire;
    logic                           w_found;
    logic [TAG_W-1:0]               w_found_idx;
    logic                           w_grant_any;
    logic [TAG_W-1:0]               w_grant_idx;

    // Outputs are forced quiet while reset is held, independent of register state.
    assign w_rsp_valid = ~reset & r_vld[LATENCY-1];
    assign w_enable    = ~reset & (~w_rsp_valid | rsp_ready);
    assign w_retire    = w_rsp_valid & rsp_ready;

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int k = NUM_REQS; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQS;
            if (req_valid[idx]) begin
                w_found     = 1'b1;
                w_found_idx = TAG_W'(idx);
            end
        end
    end

    assign w_grant_any = w_enable & w_found;
    assign w_grant_idx = w_grant_any ? w_found_idx : '0;

    always_comb begin
        req_ready = '0;
        if (w_grant_any) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // With no grant slice 0 is driven; the bubble it produces is never reported.
    assign fadd_enable = w_enable;
    assign fadd_a      = req_a[int'(w_grant_idx)*FLEN +: FLEN];
    assign fadd_b      = req_b[int'(w_grant_idx)*FLEN +: FLEN];
    assign fadd_frm    = req_frm[int'(w_grant_idx)*3 +: 3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld      <= '0;
            r_tag      <= '0;
            r_ptr      <= TAG_W'(NUM_REQS - 1);
            r_pend_cnt <= '0;
        end else if (w_enable) begin
            r_vld[0] <= w_grant_any;
            r_tag[0] <= w_grant_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_tag[s] <= r_tag[s-1];
            end
            if (w_grant_any) begin
                r_ptr <= w_grant_idx;
            end
            if (w_grant_any && !w_retire) begin
                r_pend_cnt <= r_pend_cnt + CNT_W'(1);
            end else if (!w_grant_any && w_retire) begin
                r_pend_cnt <= r_pend_cnt - CNT_W'(1);
            end
        end
    end

    assign rsp_valid  = w_rsp_valid;
    assign rsp_idx    = reset ? '0 : r_tag[LATENCY-1];
    assign rsp_y      = w_rsp_valid ? fadd_y : '0;
    assign rsp_fflags = w_rsp_valid ? fadd_fflags : '0;
    assign busy       = ~reset & (r_pend_cnt != '0);
    assign pend_cnt   = r_pend_cnt;

endmodule
